hazard_unit: RTL and testbench

Central pipeline sequencer for the five-stage MIPS datapath. It generates the per-stage enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. Inputs are instruction/data cache hit status, load-use dependencies, control-flow redirects and halt. A small state machine tracks memory waits and the sticky halt condition. Saturating counters record stall and flush activity for the testbench and debug.

---
 rtl/hazard_if.sv | 42 ++++
 rtl/hazard_unit.sv | 125 ++++++++++++
 tb/tb_hazard_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline-to-sequencer bundle: stage status flowing in, stage enables/flushes
// and debug counters flowing back out to the datapath.
interface hazard_if #(parameter int CNT_W = 16);
    logic             ihit;
    logic             dhit;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             idex_dREN;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             redirect;
    logic             halt_wb;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_rt,
               ifid_rs, ifid_rt, redirect, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_rt,
               ifid_rs, ifid_rt, redirect, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline sequencer: per-stage enable/flush and PC write control,
// memory-wait and sticky-halt tracking, saturating stall/flush counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic    CLK,
    input  logic    nRST,
    hazard_if.slave hz
);

    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

    state_t           state;
    state_t           next_state;
    logic             mem_busy;
    logic             load_use;
    logic             eval_run;
    logic             busy_eff;
    logic             halt_eff;
    logic             redirect_take;
    logic             pc_en_c;
    logic             ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic             ifid_fl_c, idex_fl_c, exmem_fl_c, memwb_fl_c;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mem_busy = (hz.exmem_dREN | hz.exmem_dWEN) & ~hz.dhit;
    // A load targeting $zero never creates a real dependency.
    assign load_use = hz.idex_dREN & (hz.idex_rt != 5'd0) &
                      ((hz.idex_rt == hz.ifid_rs) | (hz.idex_rt == hz.ifid_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        eval_run      = 1'b0;
        busy_eff      = 1'b0;
        halt_eff      = 1'b0;
        redirect_take = 1'b0;
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_en_c     = 1'b0;
        exmem_en_c    = 1'b0;
        memwb_en_c    = 1'b0;
        ifid_fl_c     = 1'b0;
        idex_fl_c     = 1'b0;
        exmem_fl_c    = 1'b0;
        memwb_fl_c    = 1'b0;

        // The dhit release cycle of MEMWAIT behaves like RUN with nothing pending in MEM.
        case (state)
            RUN: begin
                eval_run = 1'b1;
                busy_eff = mem_busy;
                halt_eff = hz.halt_wb;
            end
            MEMWAIT: eval_run = hz.dhit;
            HALT:    eval_run = 1'b0;
            default: next_state = RUN;
        endcase

        if (eval_run) begin
            next_state = RUN;
            if (halt_eff) begin
                next_state = HALT;
            end else if (busy_eff) begin
                next_state = MEMWAIT;
            end else if (hz.redirect) begin
                redirect_take = 1'b1;
                pc_en_c       = 1'b1;
                ifid_fl_c     = 1'b1;
                idex_fl_c     = 1'b1;
                exmem_fl_c    = 1'b1;
                memwb_en_c    = 1'b1;
            end else if (load_use) begin
                idex_fl_c  = 1'b1;
                exmem_en_c = 1'b1;
                memwb_en_c = 1'b1;
            end else if (!hz.ihit) begin
                ifid_fl_c  = 1'b1;
                idex_en_c  = 1'b1;
                exmem_en_c = 1'b1;
                memwb_en_c = 1'b1;
            end else begin
                pc_en_c    = 1'b1;
                ifid_en_c  = 1'b1;
                idex_en_c  = 1'b1;
                exmem_en_c = 1'b1;
                memwb_en_c = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state != HALT) && !pc_en_c) stall_cnt <= sat_inc(stall_cnt);
            if (redirect_take)               flush_cnt <= sat_inc(flush_cnt);
        end
    end

    // Controls are forced low while reset is held, independent of the inputs.
    assign hz.pc_en       = nRST & pc_en_c;
    assign hz.ifid_en     = nRST & ifid_en_c;
    assign hz.idex_en     = nRST & idex_en_c;
    assign hz.exmem_en    = nRST & exmem_en_c;
    assign hz.memwb_en    = nRST & memwb_en_c;
    assign hz.ifid_flush  = nRST & ifid_fl_c;
    assign hz.idex_flush  = nRST & idex_fl_c;
    assign hz.exmem_flush = nRST & exmem_fl_c;
    assign hz.memwb_flush = nRST & memwb_fl_c;
    assign hz.halted      = (state == HALT);
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: per-cycle comparison against a rule-level model plus
// directed literal expectations for each pipeline scenario.
module tb_hazard_unit;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;
    // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
    localparam logic [8:0] C_IDLE   = 9'b1_1111_0000;
    localparam logic [8:0] C_FREEZE = 9'b0_0000_0000;
    localparam logic [8:0] C_REDIR  = 9'b1_0001_1110;
    localparam logic [8:0] C_LDUSE  = 9'b0_0011_0100;
    localparam logic [8:0] C_FETCH  = 9'b0_0111_1000;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    hazard_if #(.CNT_W(CNT_W)) hz();
    hazard_unit #(.CNT_W(CNT_W)) dut (.CLK(CLK), .nRST(nRST), .hz(hz));

    int errors = 0;
    int checks = 0;

    bit m_on     = 1'b0;
    bit m_halted = 1'b0;
    bit m_wait   = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [8:0] dut_ctrl();
        return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush};
    endfunction

    function automatic bit f_busy();
        return (hz.exmem_dREN || hz.exmem_dWEN) && !hz.dhit;
    endfunction

    function automatic bit f_lu();
        return hz.idex_dREN && (hz.idex_rt != 0) &&
               (hz.idex_rt == hz.ifid_rs || hz.idex_rt == hz.ifid_rt);
    endfunction

    // Expected controls from the scenario currently presented on the inputs.
    function automatic logic [8:0] model_ctrl();
        bit busy;
        busy = f_busy();
        if (m_halted) return C_FREEZE;
        if (m_wait) begin
            if (!hz.dhit) return C_FREEZE;
            busy = 1'b0;
        end else if (hz.halt_wb) begin
            return C_FREEZE;
        end
        if (busy)      return C_FREEZE;
        if (hz.redirect) return C_REDIR;
        if (f_lu())    return C_LDUSE;
        if (!hz.ihit)  return C_FETCH;
        return C_IDLE;
    endfunction

    task automatic model_step(input logic [8:0] e);
        if (!m_halted) begin
            if (!e[8])       m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
            if (e == C_REDIR) m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
            if (m_wait)              m_wait = !hz.dhit;
            else if (hz.halt_wb)     m_halted = 1'b1;
            else if (f_busy())       m_wait = 1'b1;
        end
    endtask

    always @(negedge CLK) begin
        logic [8:0] e;
        if (m_on) begin
            e = model_ctrl();
            chk("model_ctrl", 32'(dut_ctrl()), 32'(e));
            chk("model_halted", 32'(hz.halted), 32'(m_halted));
            chk("model_stall_cnt", 32'(hz.stall_cnt), m_stall);
            chk("model_flush_cnt", 32'(hz.flush_cnt), m_flush);
            model_step(e);
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        m_on = 1'b0;
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("rst_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        chk("rst_halted", 32'(hz.halted), 0);
        chk("rst_stall_cnt", 32'(hz.stall_cnt), 0);
        chk("rst_flush_cnt", 32'(hz.flush_cnt), 0);
        m_halted = 1'b0;
        m_wait   = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        @(posedge CLK);
        #2 nRST = 1'b1;
        m_on = 1'b1;
    endtask

    task automatic clear_inputs();
        hz.ihit = 1'b1; hz.dhit = 1'b0;
        hz.exmem_dREN = 1'b0; hz.exmem_dWEN = 1'b0;
        hz.idex_dREN = 1'b0; hz.idex_rt = 5'd0;
        hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd0;
        hz.redirect = 1'b0; hz.halt_wb = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        for (int i = 0; i < 5; i++) begin
            next_cyc(); #1;
            chk("idle_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
        end
        chk("idle_stall_cnt", 32'(hz.stall_cnt), 0);

        // load-use through rs, then rt
        next_cyc(); hz.idex_dREN = 1'b1; hz.idex_rt = 5'd5; hz.ifid_rs = 5'd5; #1;
        chk("lu_rs_ctrl", 32'(dut_ctrl()), 32'(C_LDUSE));
        next_cyc(); clear_inputs(); #1;
        chk("lu_after_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
        next_cyc(); hz.idex_dREN = 1'b1; hz.idex_rt = 5'd0; #1;
        chk("lu_zero_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
        next_cyc(); hz.idex_rt = 5'd7; hz.ifid_rs = 5'd3; hz.ifid_rt = 5'd7; #1;
        chk("lu_rt_ctrl", 32'(dut_ctrl()), 32'(C_LDUSE));
        next_cyc(); hz.idex_rt = 5'd9; #1;
        chk("lu_nomatch_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
        next_cyc(); clear_inputs(); #1;
        chk("lu2_stall_cnt", 32'(hz.stall_cnt), 2);

        // fetch bubble
        next_cyc(); hz.ihit = 1'b0; #1;
        chk("fetch_ctrl", 32'(dut_ctrl()), 32'(C_FETCH));
        next_cyc(); hz.ihit = 1'b1; #1;
        chk("fetch_stall_cnt", 32'(hz.stall_cnt), 3);

        // load wait: 3 cycles dhit low, halt_wb ignored inside MEMWAIT
        next_cyc(); hz.exmem_dREN = 1'b1; hz.dhit = 1'b0; #1;
        chk("mw_enter_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        next_cyc(); hz.halt_wb = 1'b1; #1;
        chk("mw_wait1_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        next_cyc(); hz.halt_wb = 1'b0; #1;
        chk("mw_wait2_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        chk("mw_not_halted", 32'(hz.halted), 0);
        next_cyc(); hz.dhit = 1'b1; #1;
        chk("mw_release_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
        next_cyc(); clear_inputs(); #1;
        chk("mw_stall_cnt", 32'(hz.stall_cnt), 6);

        // store wait of one cycle, released into a redirect
        next_cyc(); hz.exmem_dWEN = 1'b1; #1;
        chk("st_enter_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        next_cyc(); hz.dhit = 1'b1; hz.redirect = 1'b1; #1;
        chk("st_release_redir", 32'(dut_ctrl()), 32'(C_REDIR));
        next_cyc(); clear_inputs(); #1;
        chk("st_stall_cnt", 32'(hz.stall_cnt), 7);
        chk("st_flush_cnt", 32'(hz.flush_cnt), 1);

        // redirect beats load-use and missing fetch
        next_cyc(); hz.redirect = 1'b1; hz.idex_dREN = 1'b1; hz.idex_rt = 5'd5;
        hz.ifid_rs = 5'd5; hz.ihit = 1'b0; #1;
        chk("redir_prio_ctrl", 32'(dut_ctrl()), 32'(C_REDIR));
        next_cyc(); clear_inputs(); #1;
        chk("redir_flush_cnt", 32'(hz.flush_cnt), 2);
        chk("redir_stall_cnt", 32'(hz.stall_cnt), 7);

        // halt is sticky
        next_cyc(); hz.halt_wb = 1'b1; hz.redirect = 1'b1; #1;
        chk("halt_cycle_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        chk("halt_cycle_halted", 32'(hz.halted), 0);
        next_cyc(); clear_inputs(); #1;
        chk("halt_next_halted", 32'(hz.halted), 1);
        for (int i = 0; i < 10; i++) begin
            next_cyc(); hz.redirect = i[0]; hz.ihit = ~i[1]; #1;
            chk("halt_frozen_ctrl", 32'(dut_ctrl()), 32'(C_FREEZE));
        end
        chk("halt_stall_cnt", 32'(hz.stall_cnt), 8);
        chk("halt_flush_cnt", 32'(hz.flush_cnt), 2);
        clear_inputs();
        do_reset();
        next_cyc(); #1;
        chk("post_rst_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
        chk("post_rst_halted", 32'(hz.halted), 0);

        // saturation of both counters
        for (int i = 0; i < SAT + 4; i++) begin
            next_cyc(); hz.ihit = 1'b0;
        end
        for (int i = 0; i < SAT + 4; i++) begin
            next_cyc(); hz.ihit = 1'b1; hz.redirect = 1'b1;
        end
        next_cyc(); clear_inputs(); #1;
        chk("sat_stall_cnt", 32'(hz.stall_cnt), SAT);
        chk("sat_flush_cnt", 32'(hz.flush_cnt), SAT);

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
